// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 register-write controller
// Sends {1, addr[6:0], data[7:0]} MSB first with nCS setup, hold and gap sequencing.
module spi_controller #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic       done,
   output logic       SCLK,
   output logic       COPI,
   output logic       nCS
);

   if (CLK_DIV < 4) begin : g_div_chk
      $error("CLK_DIV must be >= 4");
   end
   if (GAP_CYCLES < 4) begin : g_gap_chk
      $error("GAP_CYCLES must be >= 4");
   end

   localparam int MAXLEN = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int CW     = $clog2(MAXLEN) + 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   // The IDLE accept cycle is the last nCS-high cycle, so GAP itself is one shorter.
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT_HI,
      S_SHIFT_LO,
      S_HOLD,
      S_GAP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    bit_q, bit_d;
   logic [15:0]   shift_q, shift_d;
   logic          done_d;
   logic          phase_end;
   logic          in_frame_d;
   logic          sclk_q, copi_q, ncs_q, done_q, busy_q, rdy_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      done_d    = 1'b0;
      phase_end = (cnt_q == DIV_LAST);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (cmd_valid && rdy_q) begin
               state_d = S_SETUP;
               shift_d = {1'b1, cmd_addr, cmd_data};
               bit_d   = 5'd16;
            end
         end
         S_SETUP: begin
            if (phase_end) begin
               state_d = S_SHIFT_HI;
               cnt_d   = '0;
            end
         end
         S_SHIFT_HI: begin
            if (phase_end) begin
               state_d = S_SHIFT_LO;
               cnt_d   = '0;
               bit_d   = bit_q - 5'd1;
               // Next bit appears on COPI together with the SCLK fall.
               if (bit_d != 5'd0) begin
                  shift_d = {shift_q[14:0], 1'b0};
               end
            end
         end
         S_SHIFT_LO: begin
            if (phase_end) begin
               cnt_d   = '0;
               state_d = (bit_q == 5'd0) ? S_HOLD : S_SHIFT_HI;
            end
         end
         S_HOLD: begin
            if (phase_end) begin
               state_d = S_GAP;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      in_frame_d = (state_d == S_SETUP) || (state_d == S_SHIFT_HI) ||
                   (state_d == S_SHIFT_LO) || (state_d == S_HOLD);
   end

   // Outputs are registered from the next state so the pins never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         ncs_q   <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         sclk_q  <= (state_d == S_SHIFT_HI);
         copi_q  <= in_frame_d & shift_d[15];
         ncs_q   <= ~in_frame_d;
         done_q  <= done_d;
         busy_q  <= (state_d != S_IDLE);
         rdy_q   <= (state_d == S_IDLE);
      end
   end

   assign cmd_ready = rdy_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign SCLK      = sclk_q;
   assign COPI      = copi_q;
   assign nCS       = ncs_q;

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed bench for spi_controller with a peripheral model
// Frame monitor and synchronised register peripheral run beside one directed sequence.
module tb_spi_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       busy, done, SCLK, COPI, nCS;

   int n_cmp  = 0;
   int n_fail = 0;

   spi_controller #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .busy      (busy),
      .done      (done),
      .SCLK      (SCLK),
      .COPI      (COPI),
      .nCS       (nCS)
   );

   always #5 clk = ~clk;

   // Frame monitor, sampling on the falling edge
   int          cyc = 0;
   logic        prev_ncs  = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        prev_rdy  = 1'b0;
   logic [15:0] cur_bits  = '0;
   int          cur_rise  = 0;
   int          cur_low   = 0;
   int          hi_cnt    = 0;
   int          done_cnt  = 0;
   logic [15:0] fr_bits[$];
   int          fr_rise[$];
   int          fr_low[$];
   logic        fr_done[$];
   int          gap_q[$];
   int          acc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (prev_ncs && !nCS) begin
         gap_q.push_back(hi_cnt);
         cur_bits <= '0;
         cur_rise <= 0;
         cur_low  <= 1;
      end else if (!prev_ncs && nCS) begin
         fr_bits.push_back(cur_bits);
         fr_rise.push_back(cur_rise);
         fr_low.push_back(cur_low);
         fr_done.push_back(done);
         hi_cnt <= 1;
      end else if (!nCS) begin
         cur_low <= cur_low + 1;
         if (!prev_sclk && SCLK) begin
            cur_bits <= {cur_bits[14:0], COPI};
            cur_rise <= cur_rise + 1;
         end
      end else begin
         hi_cnt <= hi_cnt + 1;
      end
      if (prev_rdy && !cmd_ready && rst_n) acc_q.push_back(cyc);
      if (done) done_cnt <= done_cnt + 1;
      prev_ncs  <= nCS;
      prev_sclk <= SCLK;
      prev_rdy  <= cmd_ready;
   end

   // Register peripheral: 3-flop synchronisers, writes on nCS rise after 16 bits
   logic       per_rst_n;
   logic [2:0] s_sclk, s_copi, s_ncs;
   logic [15:0] pshift;
   int         pcnt;
   logic [7:0] pdata [0:7];

   always @(posedge clk) begin
      if (!per_rst_n) begin
         s_sclk <= '0;
         s_copi <= '0;
         s_ncs  <= 3'b111;
         pshift <= '0;
         pcnt   <= 0;
         for (int i = 0; i < 8; i++) pdata[i] <= '0;
      end else begin
         s_sclk <= {s_sclk[1:0], SCLK};
         s_copi <= {s_copi[1:0], COPI};
         s_ncs  <= {s_ncs[1:0], nCS};
         if (s_ncs[1] && !s_ncs[2]) begin
            if (pcnt == 16 && pshift[15] && pshift[14:8] < 7'd5)
               pdata[pshift[10:8]] <= pshift[7:0];
            pcnt <= 0;
         end else if (s_ncs[1]) begin
            pcnt <= 0;
         end else if (s_sclk[1] && !s_sclk[2]) begin
            pshift <= {pshift[14:0], s_copi[1]};
            pcnt   <= pcnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_cmp++;
      n_fail++;
      $error("FAIL %s: timed out waiting", tag);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         if (cmd_ready) return;
         step();
      end
      timeout("wait_idle");
   endtask

   task automatic wait_frames(input int n);
      for (int i = 0; i < 2000; i++) begin
         if (fr_bits.size() >= n) return;
         step();
      end
      timeout("wait_frames");
   endtask

   task automatic wait_rise(input int n);
      for (int i = 0; i < 400; i++) begin
         if (cur_rise >= n) return;
         step();
      end
      timeout("wait_rise");
   endtask

   task automatic wait_acc(input int n);
      for (int i = 0; i < 400; i++) begin
         if (acc_q.size() >= n) return;
         step();
      end
      timeout("wait_acc");
   endtask

   task automatic send(input logic [6:0] a, input logic [7:0] d);
      int n;
      wait_idle();
      n = acc_q.size();
      cmd_addr  = a;
      cmd_data  = d;
      cmd_valid = 1'b1;
      wait_acc(n + 1);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int base, dc;
      rst_n     = 1'b0;
      per_rst_n = 1'b0;
      cmd_valid = 1'b1;
      cmd_addr  = 7'h55;
      cmd_data  = 8'h66;
      repeat (3) step();

      // Reset values while held with cmd_valid high
      chk("rst_ncs",   32'(nCS),       32'd1);
      chk("rst_sclk",  32'(SCLK),      32'd0);
      chk("rst_copi",  32'(COPI),      32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      per_rst_n = 1'b1;
      cmd_valid = 1'b0;
      rst_n     = 1'b1;
      step();
      chk("rel_ready", 32'(cmd_ready), 32'd1);
      chk("rel_ncs",   32'(nCS),       32'd1);
      repeat (5) step();
      chk("rel_noframe", 32'(fr_bits.size() + gap_q.size()), 32'd0);
      chk("rel_busy",    32'(busy),                           32'd0);

      // Single write 0x02 / 0xA5
      send(7'h02, 8'hA5);
      wait_frames(1);
      chk("w1_bits", 32'(fr_bits[0]), 32'h82A5);
      chk("w1_rise", 32'(fr_rise[0]), 32'd16);
      chk("w1_low",  32'(fr_low[0]),  32'd136);
      chk("w1_done", 32'(fr_done[0]), 32'd1);
      wait_idle();
      chk("w1_done_cnt", 32'(done_cnt), 32'd1);

      // Back-to-back with cmd_valid held high
      base      = acc_q.size();
      cmd_addr  = 7'h01;
      cmd_data  = 8'h3C;
      cmd_valid = 1'b1;
      wait_acc(base + 1);
      cmd_addr  = 7'h04;
      cmd_data  = 8'hFF;
      wait_acc(base + 2);
      cmd_valid = 1'b0;
      wait_frames(3);
      chk("b2b_spacing", 32'(acc_q[base+1] - acc_q[base]), 32'd144);
      chk("b2b_bits0",   32'(fr_bits[1]),                  32'h813C);
      chk("b2b_bits1",   32'(fr_bits[2]),                  32'h84FF);
      chk("b2b_gap",     32'(gap_q[gap_q.size()-1]),       32'd8);
      chk("b2b_low1",    32'(fr_low[2]),                   32'd136);

      // Inputs changed mid-frame are ignored
      send(7'h03, 8'h55);
      wait_rise(3);
      cmd_addr = 7'h7F;
      cmd_data = 8'h00;
      wait_frames(4);
      chk("chg_bits", 32'(fr_bits[3]), 32'h8355);
      chk("chg_rise", 32'(fr_rise[3]), 32'd16);

      // Reset after the 7th SCLK rise
      send(7'h01, 8'h42);
      wait_rise(7);
      repeat (2) step();
      dc = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("abort_ncs",   32'(nCS),       32'd1);
      chk("abort_sclk",  32'(SCLK),      32'd0);
      chk("abort_copi",  32'(COPI),      32'd0);
      chk("abort_busy",  32'(busy),      32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd0);
      repeat (3) step();
      chk("abort_nodone", 32'(done_cnt),   32'(dc));
      chk("abort_rises",  32'(fr_rise[4]), 32'd7);
      rst_n = 1'b1;
      send(7'h00, 8'h81);
      wait_frames(6);
      chk("post_bits", 32'(fr_bits[5]), 32'h8081);
      chk("post_done", 32'(fr_done[5]), 32'd1);

      // Loopback into the peripheral, then an out-of-range address
      for (int i = 0; i < 5; i++) send(7'(i), 8'((i + 1) * 8'h11));
      send(7'h05, 8'h99);
      wait_frames(12);
      wait_idle();
      repeat (4) step();
      for (int i = 0; i < 5; i++)
         chk($sformatf("per_data%0d", i), 32'(pdata[i]), 32'((i + 1) * 17));
      chk("addr5_bits", 32'(fr_bits[11]), 32'h8599);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
